// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared state encoding and constants for the register-file port sequencer
package regfile_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_wbuf.sv
// regfile_wbuf: posted write FIFO with a parallel youngest-match lookup for operand forwarding
module regfile_wbuf
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t [DEPTH-1:0] mem, mem_n;
  logic [CW-1:0] cnt, wpos;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head_addr = mem[0].addr;
  assign head_data = mem[0].data;
  assign wpos = pop ? cnt - 1'b1 : cnt;
  // slot 0 is always the oldest entry; a pop shifts everything one slot down
  always_comb begin
    mem_n = pop ? (mem >> $bits(entry_t)) : mem;
    for (int i = 0; i < DEPTH; i++)
      if (push && CW'(i) == wpos) mem_n[i] = '{push_addr, push_data};
  end
  // later slots are younger, so the last match in the scan wins
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < cnt && mem[i].addr == lookup_addr) begin
        hit = 1'b1;
        hit_data = mem[i].data;
      end
  end
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else cnt <= cnt + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) mem <= mem_n;
endmodule

// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer: arbitrates operand reads and buffered writebacks onto the
// single shared register-file port, forwarding pending writes to reads
module regfile_port_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_rs1,
  input  logic [ADDR_W-1:0] rd_rs2,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_rd,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [31:0]       rf_register,
  output logic              rf_writeEnable,
  output logic [DATA_W-1:0] rf_writeData,
  input  logic [DATA_W-1:0] rf_readData
);
  state_t state, state_n;
  logic [ADDR_W-1:0] rs1_q, rs2_q, head_addr, lookup_addr;
  logic [DATA_W-1:0] head_data, hit_data, cap;
  logic full, empty, hit, rd_acc, push, drain;
  assign rd_ready = state == IDLE && !full;
  assign wr_ready = rd_ready;
  assign rd_acc = rd_req && rd_ready;
  assign push = wr_req && wr_ready && wr_rd != ADDR_W'(REG_ZERO);
  // no writes leave the buffer while reset is asserted; pending entries are discarded
  assign drain = rst && state == IDLE && !empty && !rd_acc;
  assign rd_valid = state == RESP;
  assign lookup_addr = state == RD1 ? rs1_q : rs2_q;
  assign cap = lookup_addr == ADDR_W'(REG_ZERO) ? '0 : hit ? hit_data : rf_readData;
  regfile_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WB_DEPTH)) u_wbuf (
    .clk(clk), .rst(rst), .push(push), .push_addr(wr_rd), .push_data(wr_data),
    .pop(drain), .full(full), .empty(empty), .head_addr(head_addr), .head_data(head_data),
    .lookup_addr(lookup_addr), .hit(hit), .hit_data(hit_data)
  );
  always_comb begin
    state_n = state == IDLE ? (rd_acc ? RD1 : IDLE) : state == RD1 ? RD2 : state == RD2 ? RESP : IDLE;
    rf_register = '0;
    rf_register[ADDR_W-1:0] = state == RD1 ? rs1_q : state == RD2 ? rs2_q : drain ? head_addr : '0;
    rf_writeEnable = drain;
    rf_writeData = drain ? head_data : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      state <= state_n;
      if (rd_acc) begin
        rs1_q <= rd_rs1;
        rs2_q <= rd_rs2;
      end
      if (state == RD1) rd_data1 <= cap;
      if (state == RD2) rd_data2 <= cap;
    end
  end
endmodule
